// File: rtl/alu_seq.sv
// alu_seq: sequential ALU with single-cycle ops and W-step iterative multiply / restoring divide.
// Define ALU_SEQ_DIV_EN to build the divider (ops DIV=3, REM=11); otherwise those opcodes are no-ops.
//   state  | meaning
//   S_IDLE | waiting for START, DONE pulses here for one cycle after completion
//   S_EXEC | operation captured; iterating while cnt_q != 0, completing when it reaches 0
module alu_seq #(
  parameter int W = 16
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         START,
  input  logic [3:0]   OP,
  input  logic [W-1:0] A,
  input  logic [W-1:0] B,
  output logic         BUSY,
  output logic         DONE,
  output logic [W-1:0] RESULT,
  output logic         ZFLAG,
  output logic         NFLAG,
  output logic         CFLAG,
  output logic         VFLAG,
  output logic         DZFLAG
);

  localparam int CW = $clog2(W + 1);
  localparam logic [CW-1:0] CNT_W   = CW'(W);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_MUL  = 4'd2;
  localparam logic [3:0] OP_AND  = 4'd4;
  localparam logic [3:0] OP_OR   = 4'd5;
  localparam logic [3:0] OP_NOTB = 4'd6;
  localparam logic [3:0] OP_PASS = 4'd7;
  localparam logic [3:0] OP_SHL  = 4'd8;
  localparam logic [3:0] OP_SHR  = 4'd9;
  localparam logic [3:0] OP_ASR  = 4'd10;
`ifdef ALU_SEQ_DIV_EN
  localparam logic [3:0] OP_DIV  = 4'd3;
  localparam logic [3:0] OP_REM  = 4'd11;
  localparam logic [W-1:0] MIN_NEG = {1'b1, {(W-1){1'b0}}};
`endif

  typedef enum logic {S_IDLE = 1'b0, S_EXEC = 1'b1} state_t;

  state_t         state_q, state_d;
  logic [3:0]     op_q, op_d;
  logic [W-1:0]   a_q, a_d, b_q, b_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [2*W-1:0] prod_q, prod_d, mcand_q, mcand_d;
  logic [W-1:0]   mplier_q, mplier_d;
  logic           done_q, done_d;
  logic [W-1:0]   result_q, result_d;
  logic           z_q, z_d, n_q, n_d, c_q, c_d, v_q, v_d, dz_q, dz_d;

  logic [W:0]     sum_w, diff_w, prod_hi_w;
  logic [W-1:0]   r_w;
  logic           c_w, v_w, dz_w, upd_w;

  assign sum_w     = {1'b0, a_q} + {1'b0, b_q};
  assign diff_w    = {1'b0, a_q} - {1'b0, b_q};
  assign prod_hi_w = prod_q[2*W-1:W-1];

`ifdef ALU_SEQ_DIV_EN
  logic [W-1:0] rem_q, rem_d, quo_q, quo_d, dvsr_q, dvsr_d;
  logic [W:0]   trial_w;
  // quo_q doubles as the dividend shifter: its MSB feeds the partial remainder each step
  assign trial_w = {rem_q, quo_q[W-1]} - {1'b0, dvsr_q};
`endif

  always_comb begin : alu_eval
    r_w   = '0;
    c_w   = 1'b0;
    v_w   = 1'b0;
    dz_w  = 1'b0;
    upd_w = 1'b1;
    case (op_q)
      OP_ADD: begin
        r_w = sum_w[W-1:0];
        c_w = sum_w[W];
        v_w = (a_q[W-1] == b_q[W-1]) && (sum_w[W-1] != a_q[W-1]);
      end
      OP_SUB: begin
        r_w = diff_w[W-1:0];
        c_w = diff_w[W];
        v_w = (a_q[W-1] != b_q[W-1]) && (diff_w[W-1] != a_q[W-1]);
      end
      OP_AND:  r_w = a_q & b_q;
      OP_OR:   r_w = a_q | b_q;
      OP_NOTB: r_w = ~b_q;
      OP_PASS: r_w = b_q;
      OP_SHL: begin
        r_w = {a_q[W-2:0], 1'b0};
        c_w = a_q[W-1];
      end
      OP_SHR: begin
        r_w = {1'b0, a_q[W-1:1]};
        c_w = a_q[0];
      end
      OP_ASR: begin
        r_w = {a_q[W-1], a_q[W-1:1]};
        c_w = a_q[0];
      end
      OP_MUL: begin
        r_w = prod_q[W-1:0];
        v_w = !((&prod_hi_w) || !(|prod_hi_w));
      end
`ifdef ALU_SEQ_DIV_EN
      OP_DIV: begin
        if (b_q == '0) dz_w = 1'b1;
        else begin
          r_w = (a_q[W-1] ^ b_q[W-1]) ? -quo_q : quo_q;
          v_w = (a_q == MIN_NEG) && (&b_q);
        end
      end
      OP_REM: begin
        if (b_q == '0) dz_w = 1'b1;
        else           r_w = a_q[W-1] ? -rem_q : rem_q;
      end
`endif
      default: upd_w = 1'b0;
    endcase
  end

  always_comb begin : fsm_next
    state_d  = state_q;
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    cnt_d    = cnt_q;
    prod_d   = prod_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    done_d   = 1'b0;
    result_d = result_q;
    z_d      = z_q;
    n_d      = n_q;
    c_d      = c_q;
    v_d      = v_q;
    dz_d     = dz_q;
`ifdef ALU_SEQ_DIV_EN
    rem_d    = rem_q;
    quo_d    = quo_q;
    dvsr_d   = dvsr_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (START) begin
          state_d  = S_EXEC;
          op_d     = OP;
          a_d      = A;
          b_d      = B;
          prod_d   = '0;
          mcand_d  = {{W{A[W-1]}}, A};
          mplier_d = B;
          cnt_d    = (OP == OP_MUL) ? CNT_W : '0;
`ifdef ALU_SEQ_DIV_EN
          rem_d    = '0;
          quo_d    = A[W-1] ? -A : A;
          dvsr_d   = B[W-1] ? -B : B;
          if (((OP == OP_DIV) || (OP == OP_REM)) && (B != '0)) cnt_d = CNT_W;
`endif
        end
      end
      S_EXEC: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
          if (op_q == OP_MUL) begin
            // the multiplier MSB carries negative weight, so the final partial product is subtracted
            if (mplier_q[0]) prod_d = prod_q + ((cnt_q == CNT_ONE) ? -mcand_q : mcand_q);
            mcand_d  = {mcand_q[2*W-2:0], 1'b0};
            mplier_d = {1'b0, mplier_q[W-1:1]};
          end
`ifdef ALU_SEQ_DIV_EN
          else begin
            rem_d = trial_w[W] ? {rem_q[W-2:0], quo_q[W-1]} : trial_w[W-1:0];
            quo_d = {quo_q[W-2:0], ~trial_w[W]};
          end
`endif
        end else begin
          state_d = S_IDLE;
          done_d  = 1'b1;
          if (upd_w) begin
            result_d = r_w;
            z_d      = (r_w == '0) && !dz_w;
            n_d      = r_w[W-1];
            c_d      = c_w;
            v_d      = v_w;
            dz_d     = dz_w;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q  <= S_IDLE;
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      cnt_q    <= '0;
      prod_q   <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      done_q   <= 1'b0;
      result_q <= '0;
      z_q      <= 1'b0;
      n_q      <= 1'b0;
      c_q      <= 1'b0;
      v_q      <= 1'b0;
      dz_q     <= 1'b0;
`ifdef ALU_SEQ_DIV_EN
      rem_q    <= '0;
      quo_q    <= '0;
      dvsr_q   <= '0;
`endif
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      cnt_q    <= cnt_d;
      prod_q   <= prod_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      done_q   <= done_d;
      result_q <= result_d;
      z_q      <= z_d;
      n_q      <= n_d;
      c_q      <= c_d;
      v_q      <= v_d;
      dz_q     <= dz_d;
`ifdef ALU_SEQ_DIV_EN
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      dvsr_q   <= dvsr_d;
`endif
    end
  end

  assign BUSY   = (state_q == S_EXEC);
  assign DONE   = done_q;
  assign RESULT = result_q;
  assign ZFLAG  = z_q;
  assign NFLAG  = n_q;
  assign CFLAG  = c_q;
  assign VFLAG  = v_q;
  assign DZFLAG = dz_q;

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: randomized self-checking bench for alu_seq (W=16) against an arithmetic reference model.
// Divider checks are included when ALU_SEQ_DIV_EN is defined.
module tb_alu_seq;

  localparam int W = 16;

  logic         CLK = 1'b0;
  logic         RST;
  logic         START;
  logic [3:0]   OP;
  logic [W-1:0] A, B;
  logic         BUSY, DONE;
  logic [W-1:0] RESULT;
  logic         ZFLAG, NFLAG, CFLAG, VFLAG, DZFLAG;
  logic [4:0]   flg;

  int n_chk  = 0;
  int n_pass = 0;

  logic [W-1:0] exp_res;
  logic [4:0]   exp_flg;  // {Z,N,C,V,DZ}

  alu_seq #(.W(W)) dut (
    .CLK(CLK), .RST(RST), .START(START), .OP(OP), .A(A), .B(B),
    .BUSY(BUSY), .DONE(DONE), .RESULT(RESULT),
    .ZFLAG(ZFLAG), .NFLAG(NFLAG), .CFLAG(CFLAG), .VFLAG(VFLAG), .DZFLAG(DZFLAG)
  );

  assign flg = {ZFLAG, NFLAG, CFLAG, VFLAG, DZFLAG};

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic bit out_of_range(input longint x);
    return (x > 32767) || (x < -32768);
  endfunction

  // Updates the expected result/flags from the arithmetic meaning of each opcode; returns latency in edges.
  task automatic model(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       output int lat);
    longint sa, sb, ua, ub, full;
    logic [W-1:0] r;
    bit c, v, dz, upd;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'(a);
    ub = longint'(b);
    r = '0; c = 0; v = 0; dz = 0; upd = 1; lat = 1; full = 0;
    case (op)
      4'd0: begin full = ua + ub; r = full[15:0]; c = full[16]; v = out_of_range(sa + sb); end
      4'd1: begin full = ua - ub; r = full[15:0]; c = (ua < ub); v = out_of_range(sa - sb); end
      4'd2: begin full = sa * sb; r = full[15:0]; v = out_of_range(full); lat = W + 1; end
      4'd4: r = a & b;
      4'd5: r = a | b;
      4'd6: r = ~b;
      4'd7: r = b;
      4'd8: begin full = ua * 2; r = full[15:0]; c = full[16]; end
      4'd9: begin full = ua / 2; r = full[15:0]; c = ua[0]; end
      4'd10: begin full = sa >>> 1; r = full[15:0]; c = ua[0]; end
`ifdef ALU_SEQ_DIV_EN
      4'd3, 4'd11: begin
        if (b == 0) dz = 1;
        else begin
          lat = W + 1;
          if (op == 4'd3) begin full = sa / sb; v = out_of_range(full); end
          else full = sa % sb;
          r = full[15:0];
        end
      end
`endif
      default: upd = 0;
    endcase
    if (upd) begin
      exp_res = r;
      exp_flg = dz ? 5'b00001 : {r == 0, r[15], c, v, 1'b0};
    end
  endtask

  // Called #1 after a rising edge with the DUT idle or in its DONE cycle.
  task automatic run_op(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input bit poke);
    int lat, n;
    model(op, a, b, lat);
    START = 1'b1; OP = op; A = a; B = b;
    @(posedge CLK); #1;
    START = 1'b0; OP = 4'($urandom); A = 16'($urandom); B = 16'($urandom);
    chk("busy_after_start", BUSY, 1);
    n = 0;
    while (!DONE && n < 40) begin
      if (poke) START = 1'($urandom_range(0, 1));
      @(posedge CLK); #1;
      n++;
      if (!DONE) chk("busy_mid", BUSY, 1);
    end
    START = 1'b0;
    chk($sformatf("latency op%0d", op), n, lat);
    chk("busy_at_done", BUSY, 0);
    chk($sformatf("result op%0d a=%h b=%h", op, a, b), RESULT, exp_res);
    chk($sformatf("flags op%0d a=%h b=%h", op, a, b), flg, exp_flg);
  endtask

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 7))
      0: return 16'h0000;
      1: return 16'h8000;
      2: return 16'hFFFF;
      3: return 16'h7FFF;
      4: return 16'h0001;
      default: return 16'($urandom);
    endcase
  endfunction

  initial begin
    RST = 1'b1; START = 1'b0; OP = '0; A = '0; B = '0;
    exp_res = '0; exp_flg = '0;
    #12;
    chk("reset_busy", BUSY, 0);
    chk("reset_done", DONE, 0);
    chk("reset_result", RESULT, 0);
    chk("reset_flags", flg, 0);
    @(negedge CLK); RST = 1'b0;
    @(posedge CLK); #1;

    run_op(4'd0, 16'h7FFF, 16'h0001, 0);
    chk("add_ovf_result", RESULT, 16'h8000);
    chk("add_ovf_flags", flg, 5'b01010);
    run_op(4'd1, 16'h0003, 16'h0005, 0);
    chk("sub_borrow_result", RESULT, 16'hFFFE);
    chk("sub_borrow_flags", flg, 5'b01100);
    run_op(4'd1, 16'h0005, 16'h0005, 0);
    chk("sub_zero_flags", flg, 5'b10000);
    run_op(4'd2, 16'hFFFD, 16'h0007, 1);
    chk("mul_result", RESULT, 16'hFFEB);
    chk("mul_flags", flg, 5'b01000);
`ifdef ALU_SEQ_DIV_EN
    run_op(4'd3, 16'hFFF9, 16'h0002, 0);
    chk("div_neg_result", RESULT, 16'hFFFD);
    run_op(4'd11, 16'hFFF9, 16'h0002, 0);
    chk("rem_neg_result", RESULT, 16'hFFFF);
    run_op(4'd3, 16'h0005, 16'h0000, 0);
    chk("div_zero_flags", flg, 5'b00001);
    run_op(4'd3, 16'h8000, 16'hFFFF, 0);
    chk("div_ovf_result", RESULT, 16'h8000);
    chk("div_ovf_flags", flg, 5'b01010);
`endif
    run_op(4'd13, 16'h1234, 16'h5678, 0);

    // Abort a multiply with an asynchronous reset mid-cycle.
    START = 1'b1; OP = 4'd2; A = 16'h1234; B = 16'h0F0F;
    @(posedge CLK); #1;
    START = 1'b0;
    repeat (4) @(posedge CLK);
    #2 RST = 1'b1;
    #1;
    chk("abort_busy", BUSY, 0);
    chk("abort_done", DONE, 0);
    chk("abort_result", RESULT, 0);
    chk("abort_flags", flg, 0);
    exp_res = '0; exp_flg = '0;
    @(negedge CLK); RST = 1'b0;
    @(posedge CLK); #1;
    run_op(4'd0, 16'h0002, 16'h0003, 0);
    chk("post_reset_add", RESULT, 16'h0005);

    for (int i = 0; i < 250; i++) begin
      run_op(4'($urandom_range(0, 15)), pick(), pick(), 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(1, 3)) begin
          @(posedge CLK); #1;
          chk("done_single_pulse", DONE, 0);
          chk("result_hold", RESULT, exp_res);
        end
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
